// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory request
// at a time, and hands each fetched word and its address to decode through a
// valid/ready handshake. Redirects reload the PC and squash any stale fetch.
//
// state  | meaning
// -------+-------------------------------------------------------------
// BOOT   | first cycle after reset, no request yet
// REQ    | request to pc is driven this cycle (unless redirected)
// WAIT   | one request outstanding, waiting for its response
// HOLD   | fetched instruction presented to decode, waiting for ready
// DROP   | redirected while a request was outstanding, absorbing it
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] target_pc,
  input  logic        inst_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        inst_valid
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_valid_q;
  logic [31:0] target_word;

  // Redirect targets are word aligned; the low two bits are simply dropped.
  assign target_word = target_pc & ~32'h0000_0003;

  // A redirect in REQ suppresses the request so the stale PC never reaches memory.
  assign imem_req    = (state == S_REQ) && !redirect;
  assign imem_addr   = pc;
  assign instruction = inst_valid_q ? inst_q : NOP_INST;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = inst_valid_q;

  // Fetch sequencing, PC update and capture of the returned instruction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_BOOT;
      pc           <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_pc_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_REQ;
        end
        S_REQ: begin
          if (redirect) begin
            pc <= target_word;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect && imem_rvalid) begin
            pc    <= target_word;
            state <= S_REQ;
          end else if (redirect) begin
            pc    <= target_word;
            state <= S_DROP;
          end else if (imem_rvalid) begin
            inst_q       <= imem_rdata;
            inst_pc_q    <= pc;
            inst_valid_q <= 1'b1;
            pc           <= pc + 32'd4;
            state        <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Redirect wins over ready: the held instruction is on the wrong path.
          if (redirect) begin
            inst_valid_q <= 1'b0;
            pc           <= target_word;
            state        <= S_REQ;
          end else if (inst_ready) begin
            inst_valid_q <= 1'b0;
            state        <= S_REQ;
          end
        end
        S_DROP: begin
          if (redirect) begin
            pc <= target_word;
          end
          if (imem_rvalid) begin
            state <= S_REQ;
          end
        end
        default: begin
          state <= S_BOOT;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage, the producer that feeds the `decode` block. It holds the program counter and issues one request at a time to instruction memory, tolerating any memory response latency. It presents each fetched instruction and its PC to decode through a valid/ready handshake. It accepts PC redirects from branch/jump resolution and discards any in-flight stale fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, PC of the first fetch after reset.
- `NOP_INST`, 32'h0000_0013, value driven on `instruction` when no valid instruction is held (`addi zero, zero, 0`).

Ports:
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low. Asserting it forces the reset state immediately.
- `redirect`  in  1  load `target_pc` as the next fetch PC, kill the current fetch.
- `target_pc`  in  32  redirect destination. Bits [1:0] are ignored and treated as 0.
- `inst_ready`  in  1  decode accepts the held instruction this cycle.
- `imem_req`  out  1  one-cycle request pulse to instruction memory.
- `imem_addr`  out  32  request address, equal to the PC register.
- `imem_rvalid`  in  1  memory returns data. Exactly one pulse per request, at least 1 cycle after it.
- `imem_rdata`  in  32  returned instruction word.
- `instruction`  out  32  held instruction, or `NOP_INST` when `inst_valid`=0.
- `inst_pc`  out  32  address of the held instruction.
- `inst_valid`  out  1  `instruction`/`inst_pc` are valid.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `inst_q`, `inst_pc_q`, `inst_valid_q`.
  - State: BOOT, REQ, WAIT, HOLD, DROP.
- Reset values:
  - state=BOOT, `pc`=`RESET_PC`.
  - `inst_valid`=0, `instruction`=`NOP_INST`, `inst_pc`=`RESET_PC`.
  - `imem_req`=0. `imem_addr`=`RESET_PC`.
- Outputs:
  - `imem_req` = (state==REQ) && !`redirect`.
  - `imem_addr` = `pc`.
- BOOT: go to REQ unconditionally. No request is issued in this state.
- REQ:
  - If `redirect`: `pc`<=`target_pc`&~3, stay in REQ, no request issued.
  - Otherwise the request is issued and the state goes to WAIT.
- WAIT, evaluated in priority order:
  - `redirect` && `imem_rvalid`: discard data, `pc`<=target, go to REQ.
  - `redirect`: `pc`<=target, go to DROP.
  - `imem_rvalid`: `inst_q`<=`imem_rdata`, `inst_pc_q`<=`pc`, `inst_valid`<=1, `pc`<=`pc`+4, go to HOLD.
- HOLD:
  - `redirect`: `inst_valid`<=0, `pc`<=target, go to REQ. Redirect has priority over `inst_ready`, so the held instruction is dropped.
  - Else `inst_ready`: `inst_valid`<=0, go to REQ.
  - Else: hold all outputs stable.
- DROP: wait for the stale response.
  - A `redirect` here updates `pc` again.
  - On `imem_rvalid`: discard the data and go to REQ. If `redirect` is asserted in the same cycle, the new target is still taken.
- PC arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- At most one memory request is outstanding. `imem_rvalid` in BOOT, REQ or HOLD is a protocol error and is ignored.

## Timing
- With a 1-cycle memory, if reset releases before edge 0:
  - Edge 0: BOOT→REQ. `imem_req`=1 during cycle 0–1.
  - Edge 1: →WAIT.
  - Edge 2: `rvalid` is sampled; →HOLD, and `inst_valid`=1 after edge 2.
  - The consume edge returns to REQ.
- Throughput: one instruction per 3 cycles at minimum (REQ, WAIT, HOLD), plus extra memory latency and decode stall cycles.
- Redirect-to-request latency:
  - From REQ or HOLD: the request is issued in the next cycle.
  - From WAIT or DROP: the request is issued one cycle after the stale response is absorbed.
- `instruction` and `inst_pc` are registered and change only on the edge that sets `inst_valid`. `instruction` reads `NOP_INST` combinationally whenever `inst_valid`=0.
- Asserting `reset` mid-fetch returns the block to BOOT immediately. A response arriving after reset release while in BOOT or REQ is ignored.

## Test plan
- Reset, then 1-cycle memory with `inst_ready`=1, returning 32'hFFF00593 (`addi a1, zero, -1`) at address 0 → `imem_req` pulses at addresses 0, 4, 8 every 3 cycles. `inst_valid`=1 with `instruction`=32'hFFF00593 and `inst_pc`=0. `instruction`=32'h00000013 while `inst_valid`=0.
- Hold `inst_ready`=0 for 5 cycles in HOLD → `instruction`/`inst_pc` stable, no `imem_req` issued. Raising `inst_ready` → `inst_valid` drops and the next request goes to `pc`+4.
- Redirect to 32'h0000_0103 while in WAIT with 4-cycle memory latency → stale data is never presented. The next request goes to 32'h0000_0100 after the stale `rvalid`.
- Redirect on the same cycle as `imem_rvalid`, and redirect while in HOLD → data is dropped, `inst_valid`=0, and a request to the target is issued the next cycle.
- Set `pc` to 32'hFFFF_FFFC via redirect, then fetch → `inst_pc`=32'hFFFF_FFFC and the next request address is 32'h0000_0000.
- Assert `reset` while in WAIT → outputs return to reset values asynchronously. A late `rvalid` after release does not set `inst_valid`, and the first request goes to `RESET_PC`.
